// File: rtl/ir_camera_init_seq.sv
// Power-up command sequencer for the IR camera I2C master: waits, then issues six
// two-byte register writes with a gap after each, reporting completion or a stalled master.
module ir_camera_init_seq #(
    parameter logic [6:0] DEV_ADDR       = 7'h58,
    parameter int         POWERUP_CYCLES = 1000,
    parameter int         GAP_CYCLES     = 500,
    parameter int         BUSY_TIMEOUT   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        i2c_ready,
    output logic [6:0]  i2c_addr,
    output logic [95:0] i2c_data,
    output logic [4:0]  i2c_packets,
    output logic        i2c_rw,
    output logic        i2c_start,
    output logic [2:0]  cmd_index,
    output logic        init_done,
    output logic        init_error
);

    typedef enum logic [2:0] {
        POWERUP    = 3'd0,
        WAIT_READY = 3'd1,
        WAIT_BUSY  = 3'd2,
        WAIT_DONE  = 3'd3,
        GAP        = 3'd4,
        DONE       = 3'd5,
        ERROR      = 3'd6
    } state_t;

    localparam logic [23:0] POWERUP_LOAD = 24'(POWERUP_CYCLES - 1);
    localparam logic [23:0] GAP_LOAD     = 24'(GAP_CYCLES - 1);
    localparam logic [7:0]  TMO_LAST     = 8'(BUSY_TIMEOUT - 1);
    localparam logic [2:0]  LAST_CMD     = 3'd5;

    // First byte on the wire is [15:8], second is [7:0].
    function automatic logic [15:0] rom(input logic [2:0] idx);
        case (idx)
            3'd0:    rom = 16'h3001;
            3'd1:    rom = 16'h3008;
            3'd2:    rom = 16'h0690;
            3'd3:    rom = 16'h08C0;
            3'd4:    rom = 16'h1A40;
            3'd5:    rom = 16'h3333;
            default: rom = 16'h0000;
        endcase
    endfunction

    state_t      state_reg, state_next;
    logic [23:0] cnt_reg, cnt_next;
    logic [7:0]  tmo_reg, tmo_next;
    logic [2:0]  cmd_reg, cmd_next;
    logic        start_reg, start_next;
    logic        done_reg, done_next;
    logic        error_reg, error_next;
    logic [15:0] data_reg, data_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= POWERUP;
            cnt_reg   <= POWERUP_LOAD;
            tmo_reg   <= 8'd0;
            cmd_reg   <= 3'd0;
            start_reg <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            data_reg  <= rom(3'd0);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tmo_reg   <= tmo_next;
            cmd_reg   <= cmd_next;
            start_reg <= start_next;
            done_reg  <= done_next;
            error_reg <= error_next;
            data_reg  <= data_next;
        end
    end

    // The shared down-counter is reloaded on entry to POWERUP/GAP and the state
    // leaves on the cycle it reads zero, so each lasts exactly N cycles.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tmo_next   = tmo_reg;
        cmd_next   = cmd_reg;
        case (state_reg)
            POWERUP: begin
                if (cnt_reg == 24'd0) state_next = WAIT_READY;
                else                  cnt_next   = cnt_reg - 24'd1;
            end
            WAIT_READY: begin
                if (i2c_ready) begin
                    state_next = WAIT_BUSY;
                    tmo_next   = 8'd0;
                end
            end
            WAIT_BUSY: begin
                if (!i2c_ready)                state_next = WAIT_DONE;
                else if (tmo_reg == TMO_LAST)  state_next = ERROR;
                else                           tmo_next   = tmo_reg + 8'd1;
            end
            WAIT_DONE: begin
                if (i2c_ready) begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt_reg == 24'd0) begin
                    if (cmd_reg == LAST_CMD) begin
                        state_next = DONE;
                    end else begin
                        cmd_next   = cmd_reg + 3'd1;
                        state_next = WAIT_READY;
                    end
                end else begin
                    cnt_next = cnt_reg - 24'd1;
                end
            end
            DONE, ERROR: begin
                if (restart) begin
                    cmd_next   = 3'd0;
                    state_next = POWERUP;
                    cnt_next   = POWERUP_LOAD;
                end
            end
            default: state_next = POWERUP;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        start_next = (state_reg == WAIT_READY) && i2c_ready;
        done_next  = (state_next == DONE);
        error_next = (state_next == ERROR);
        data_next  = rom(cmd_next);
    end

    assign i2c_addr    = DEV_ADDR;
    assign i2c_packets = 5'd2;
    assign i2c_rw      = 1'b0;
    assign i2c_data    = {80'd0, data_reg};
    assign i2c_start   = start_reg;
    assign cmd_index   = cmd_reg;
    assign init_done   = done_reg;
    assign init_error  = error_reg;

endmodule

// File: doc/ir_camera_init_seq.md
# ir_camera_init_seq

Upstream command sequencer for the I2C master. After reset and a power-up delay it issues the fixed six-write initialisation sequence for the IR camera (7-bit address 0x58), one two-byte write per transaction. Between transactions it waits for the master to finish and then holds for a programmable gap. It flags completion, or a stalled master, to the tracking logic. Its outputs connect directly to the master's addr/data/packets/start/rw inputs, and its `i2c_ready` input is driven from the master's ready output.

## Interface
Parameters:
- DEV_ADDR, 7'h58: 7-bit target address placed on `i2c_addr`.
- POWERUP_CYCLES, 1000: idle cycles after reset release before the first command (1..2^24-1).
- GAP_CYCLES, 500: idle cycles after each transaction completes before the next one (1..2^24-1).
- BUSY_TIMEOUT, 8: maximum cycles to wait for `i2c_ready` to fall after `i2c_start` (1..255).

Ports:
- clk, in, 1: single clock; the master is clocked by the same net.
- reset, in, 1: synchronous, active-high.
- restart, in, 1: one-cycle pulse; re-runs the sequence from `DONE` or `ERROR`; ignored in all other states.
- i2c_ready, in, 1: master idle/stop indication.
- i2c_addr, out, 7: constant DEV_ADDR.
- i2c_data, out, 96: command bytes; bits [95:16] are always 0.
- i2c_packets, out, 5: constant 2.
- i2c_rw, out, 1: constant 0 (write).
- i2c_start, out, 1: one-cycle request pulse.
- cmd_index, out, 3: index of the current or next command (0..5).
- init_done, out, 1: sequence complete.
- init_error, out, 1: master failed to go busy.

## Operation
- Command ROM: the byte transmitted first is `i2c_data[15:8]`; the byte transmitted second is `i2c_data[7:0]`.
  - 0: 16'h3001
  - 1: 16'h3008
  - 2: 16'h0690
  - 3: 16'h08C0
  - 4: 16'h1A40
  - 5: 16'h3333
- `i2c_data` always equals ROM[cmd_index] and is stable throughout a transaction.
- State machine:
  - POWERUP: count POWERUP_CYCLES, then go to WAIT_READY.
  - WAIT_READY: when `i2c_ready`=1, assert `i2c_start` for exactly one cycle, clear the timeout counter, and go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE on the first cycle with `i2c_ready`=0. If BUSY_TIMEOUT cycles elapse without that, go to ERROR.
  - WAIT_DONE: go to GAP on the first cycle with `i2c_ready`=1.
  - GAP: count GAP_CYCLES. At expiry:
    - if cmd_index==5, go to DONE;
    - otherwise increment cmd_index and go to WAIT_READY.
  - DONE: `init_done`=1. On `restart`, set cmd_index=0 and go to POWERUP.
  - ERROR: `init_error`=1 and cmd_index is held. On `restart`, set cmd_index=0 and go to POWERUP.
- A single 24-bit down-counter is shared by POWERUP and GAP. It is loaded with (N−1) on state entry, and the state exits on the cycle the counter reads 0, so each of those states lasts exactly N cycles.
- `reset` during any state forces POWERUP on the next edge; an in-flight master transaction is abandoned without a stop handshake.

## Timing
- Reset values:
  - state=POWERUP, cmd_index=0, `i2c_start`=0, `init_done`=0, `init_error`=0.
  - `i2c_addr`=DEV_ADDR, `i2c_packets`=2, `i2c_rw`=0, `i2c_data`=16'h3001.
- All outputs are registered. `i2c_start` rises on the edge after `i2c_ready`=1 is sampled in WAIT_READY and falls on the following edge.
- The master samples `start` in its idle state, so `i2c_ready` falls one cycle after `i2c_start` is seen. The default BUSY_TIMEOUT=8 covers this with margin.
- The master's ready is high in both its STOP and IDLE states. WAIT_DONE therefore exits on the first high cycle (STOP), and GAP ≥1 guarantees the master has reached IDLE before the next `i2c_start`.
- `restart` and `reset` asserted in the same cycle: reset wins.
- `restart` outside DONE/ERROR: ignored, with no effect on counters.
- Total sequence length with an ideal master whose transaction occupies T cycles: POWERUP_CYCLES + 6·(1 + 1 + T + GAP_CYCLES) cycles, with the exact per-stage accounting checked by the bench.

## Test plan
- Reset release with POWERUP=8, GAP=4 and a master model (busy 1 cycle after start, for 30 cycles) -> first `i2c_start` exactly 9 cycles after reset falls; six pulses in total, with `i2c_data[15:0]` = 3001, 3008, 0690, 08C0, 1A40, 3333; then `init_done`=1 and no further starts.
- Master model whose ready never falls -> `init_error`=1 exactly BUSY_TIMEOUT cycles after the first start; cmd_index=0; no second start.
- `i2c_ready` held low at WAIT_READY for 20 cycles -> no start until it rises; start appears 1 cycle after the rise.
- Reset asserted during WAIT_DONE of command 3 -> outputs return to reset values; the sequence restarts from command 0 after POWERUP.
- `restart` in DONE -> `init_done` falls next cycle; the full six-command sequence repeats. `restart` during GAP -> no effect.
- Simultaneous `restart` and `reset` in ERROR -> reset behaviour; `init_error`=0 next cycle.
